// File: rtl/mux8_rr_arbiter_if.sv
// Handshake bundle between the eight requesters and the mux select arbiter.
// The master is the requester side and the slave is the arbiter.
interface mux8_rr_arbiter_if;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic [2:0] sel;
   logic       valid;

   modport master (output req, output done, input grant, input sel, input valid);
   modport slave  (input req, input done, output grant, output sel, output valid);
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner selection for the shared 8:1 mux, with a bounded hold quantum
// and hand-off between owners that leaves no idle cycle.
module mux8_rr_arbiter #(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 4
) (
   input  logic               clk,
   input  logic               rst,
   mux8_rr_arbiter_if.slave   bus
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [7:0]       grant_q, grant_d;
   logic [2:0]       sel_q,   sel_d;
   logic             valid_q, valid_d;
   logic [2:0]       ptr_q,   ptr_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   logic [7:0] owner_oh;
   logic [7:0] cand;
   logic [2:0] win_req;
   logic [2:0] win_cand;
   logic [7:0] win_req_oh;
   logic [7:0] win_cand_oh;
   logic       rel;

   // First set bit of vec scanning upward from p with wrap 7->0.
   function automatic logic [2:0] win(input logic [7:0] vec, input logic [2:0] p);
      logic [2:0] idx;
      logic       found;
      win   = p;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = p + 3'(i);
         if (!found && vec[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_dec
         assign owner_oh[gi]    = (sel_q == 3'(gi));
         assign cand[gi]        = bus.req[gi] & ~owner_oh[gi];
         assign win_req_oh[gi]  = (win_req == 3'(gi));
         assign win_cand_oh[gi] = (win_cand == 3'(gi));
      end
   endgenerate

   assign win_req  = win(bus.req, ptr_q);
   assign win_cand = win(cand, sel_q + 3'd1);

   // done and quantum expiry coinciding both land here; done alone decides re-grant below.
   assign rel = bus.done | ~bus.req[sel_q] | (cnt_q == CNT_W'(MAX_HOLD));

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|bus.req) begin
               state_d = ST_GRANT;
               grant_d = win_req_oh;
               sel_d   = win_req;
               valid_d = 1'b1;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_GRANT: begin
            if (!rel) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               ptr_d = sel_q + 3'd1;
               if (|cand) begin
                  grant_d = win_cand_oh;
                  sel_d   = win_cand;
                  cnt_d   = CNT_W'(1);
               end else if (bus.req[sel_q] && !bus.done) begin
                  cnt_d = CNT_W'(1);
               end else begin
                  // sel is left as-is; the mux output is don't-care while idle.
                  state_d = ST_IDLE;
                  grant_d = 8'h00;
                  valid_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 8'h00;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= 8'h00;
         sel_q   <= 3'd0;
         valid_q <= 1'b0;
         ptr_q   <= 3'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.grant = grant_q;
   assign bus.sel   = sel_q;
   assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: two instances (hold quantum 4 and 1) share stimulus and are
// checked against directed expectations and an arbitration model.
module tb_mux8_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;
   logic       done = 1'b0;

   int checks = 0;
   int failures = 0;

   localparam int HOLD [2] = '{4, 1};

   mux8_rr_arbiter_if bus0 ();
   mux8_rr_arbiter_if bus1 ();

   assign bus0.req  = req;
   assign bus0.done = done;
   assign bus1.req  = req;
   assign bus1.done = done;

   mux8_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus0));
   mux8_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   always #5 clk = ~clk;

   logic [7:0] g [2];
   logic [2:0] s [2];
   logic       v [2];
   assign g[0] = bus0.grant;
   assign s[0] = bus0.sel;
   assign v[0] = bus0.valid;
   assign g[1] = bus1.grant;
   assign s[1] = bus1.sel;
   assign v[1] = bus1.valid;

   // Reference model: who owns the mux, how long they have held it, where the next search starts.
   int m_owner [2];
   int m_held  [2];
   int m_next  [2];
   bit m_busy  [2];

   function automatic int pick(input logic [7:0] vec, input int start);
      for (int off = 0; off < 8; off++)
         if (vec[(start + off) % 8]) return (start + off) % 8;
      return -1;
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_busy[d] = 0; m_owner[d] = 0; m_next[d] = 0; m_held[d] = 0;
         end else if (!m_busy[d]) begin
            if (req != 8'h00) begin
               m_owner[d] = pick(req, m_next[d]);
               m_busy[d]  = 1;
               m_held[d]  = 1;
            end
         end else if (!(done || !req[m_owner[d]] || m_held[d] == HOLD[d])) begin
            m_held[d]++;
         end else begin
            logic [7:0] others;
            others = req;
            others[m_owner[d]] = 1'b0;
            m_next[d] = (m_owner[d] + 1) % 8;
            if (others != 8'h00) begin
               m_owner[d] = pick(others, m_next[d]);
               m_held[d]  = 1;
            end else if (req[m_owner[d]] && !done) begin
               m_held[d] = 1;
            end else begin
               m_busy[d] = 0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 8'h00; done = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 8'hFF; done = 1'b1;
      for (int c = 0; c < 2; c++) begin
         step();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (g[d] !== 8'h00 || s[d] !== 3'd0 || v[d] !== 1'b0) begin
               failures++;
               $display("FAIL reset dut%0d cyc=%0d got grant=%h sel=%0d valid=%b want 00/0/0", d, c, g[d], s[d], v[d]);
            end
         end
      end
      rst = 1'b0; req = 8'h00; done = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (g[d] !== 8'h00 || v[d] !== 1'b0) begin
               failures++;
               $display("FAIL reset_idle dut%0d cyc=%0d got grant=%h valid=%b want 00/0", d, c, g[d], v[d]);
            end
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      req = 8'h20; done = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (g[d] !== 8'h20 || s[d] !== 3'd5 || v[d] !== 1'b1) begin
               failures++;
               $display("FAIL single_hold dut%0d cyc=%0d got grant=%h sel=%0d valid=%b want 20/5/1", d, c, g[d], s[d], v[d]);
            end
         end
      end
      done = 1'b1; req = 8'h00;
      step();
      done = 1'b0;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (g[d] !== 8'h00 || v[d] !== 1'b0) begin
            failures++;
            $display("FAIL single_release dut%0d got grant=%h valid=%b want 00/0", d, g[d], v[d]);
         end
      end
   endtask

   task automatic test_round_robin();
      int exp_sel;
      do_reset();
      req = 8'hFF; done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step();
         for (int d = 0; d < 2; d++) begin
            exp_sel = (k / HOLD[d]) % 8;
            checks++;
            if (s[d] !== 3'(exp_sel) || g[d] !== (8'h01 << exp_sel) || v[d] !== 1'b1) begin
               failures++;
               $display("FAIL round_robin dut%0d k=%0d got grant=%h sel=%0d valid=%b want sel=%0d", d, k, g[d], s[d], v[d], exp_sel);
            end
         end
      end
   endtask

   task automatic test_wrap_skip();
      do_reset();
      req = 8'h20; done = 1'b0;
      step();
      done = 1'b1; req = 8'h09;
      step();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (g[d] !== 8'h01 || s[d] !== 3'd0 || v[d] !== 1'b1) begin
            failures++;
            $display("FAIL wrap dut%0d got grant=%h sel=%0d valid=%b want 01/0/1", d, g[d], s[d], v[d]);
         end
      end
      step();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (g[d] !== 8'h08 || s[d] !== 3'd3 || v[d] !== 1'b1) begin
            failures++;
            $display("FAIL skip dut%0d got grant=%h sel=%0d valid=%b want 08/3/1", d, g[d], s[d], v[d]);
         end
      end
      req = 8'h00;
      step();
      done = 1'b0;
   endtask

   task automatic test_early_release();
      do_reset();
      req = 8'h14; done = 1'b0;
      step();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (g[d] !== 8'h04 || s[d] !== 3'd2) begin
            failures++;
            $display("FAIL early_first dut%0d got grant=%h sel=%0d want 04/2", d, g[d], s[d]);
         end
      end
      req = 8'h10;
      step();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (g[d] !== 8'h10 || s[d] !== 3'd4 || v[d] !== 1'b1) begin
            failures++;
            $display("FAIL early_move dut%0d got grant=%h sel=%0d valid=%b want 10/4/1", d, g[d], s[d], v[d]);
         end
      end
      done = 1'b1; req = 8'h00;
      step();
      done = 1'b0;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (g[d] !== 8'h00 || v[d] !== 1'b0 || s[d] !== 3'd4) begin
            failures++;
            $display("FAIL early_idle dut%0d got grant=%h sel=%0d valid=%b want 00/4/0", d, g[d], s[d], v[d]);
         end
      end
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      req = 8'h08; done = 1'b0;
      repeat (3) step();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (g[d] !== 8'h08) begin
            failures++;
            $display("FAIL midrst_pre dut%0d got grant=%h want 08", d, g[d]);
         end
      end
      rst = 1'b1;
      step();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (g[d] !== 8'h00 || s[d] !== 3'd0 || v[d] !== 1'b0) begin
            failures++;
            $display("FAIL midrst dut%0d got grant=%h sel=%0d valid=%b want 00/0/0", d, g[d], s[d], v[d]);
         end
      end
      rst = 1'b0; req = 8'h88;
      step();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (g[d] !== 8'h08 || s[d] !== 3'd3) begin
            failures++;
            $display("FAIL midrst_first dut%0d got grant=%h sel=%0d want 08/3", d, g[d], s[d]);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] exp_g;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 79) == 0);
         case ($urandom_range(0, 5))
            0:       req = 8'($urandom);
            1:       req = 8'h01 << $urandom_range(0, 7);
            2:       req = req ^ (8'h01 << $urandom_range(0, 7));
            default: req = req;
         endcase
         done = ($urandom_range(0, 4) == 0);
         step();
         for (int d = 0; d < 2; d++) begin
            exp_g = m_busy[d] ? (8'h01 << m_owner[d]) : 8'h00;
            checks++;
            if (g[d] !== exp_g || v[d] !== m_busy[d] || s[d] !== 3'(m_owner[d])) begin
               failures++;
               $display("FAIL random dut%0d cyc=%0d got grant=%h sel=%0d valid=%b want %h/%0d/%b",
                        d, c, g[d], s[d], v[d], exp_g, m_owner[d], m_busy[d]);
            end
         end
      end
      rst = 1'b0; req = 8'h00; done = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_wrap_skip();
      test_early_release();
      test_reset_mid_grant();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter that shares the 8:1 select datapath between eight requesters. It drives the 3-bit select of mux_8_1 so that the mux output follows the current owner's input. It enforces a maximum hold quantum per grant and hands off back-to-back with no idle cycle. It sits between the requester logic and the mux select port in the CA datapath.

Parameters:
MAX_HOLD, 4, maximum consecutive cycles one owner may hold the grant; legal range 1..15.
CNT_W, 4, width of the hold counter; fixed, and must hold MAX_HOLD.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
req  input  8  request vector; req[k]=1 means requester k wants the mux
done  input  1  current owner releases the grant; sampled only while valid=1
grant  output  8  one-hot grant, registered; all zeros when idle
sel  output  3  registered select for mux_8_1 s[2:0]; equals the index of the set grant bit
valid  output  1  registered; 1 while grant is non-zero

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. The ports are named clk and rst.
- Reset values, applied at the edge where rst=1: grant=8'h00, sel=3'd0, valid=0, ptr=3'd0, cnt=0, state=IDLE. Reset overrides all other inputs, including mid-grant.
- Internal state: ptr[2:0] is the search start, cnt[CNT_W-1:0] is the hold counter, and state is IDLE or GRANT.
- Winner function win(vec, p): the first set bit of vec, scanning p, p+1, ..., 7, 0, ..., p-1 (wraps 7->0).
- IDLE state:
  - done is ignored.
  - If req!=0 at the edge, the next state is GRANT. Set grant=onehot(w), sel=w, valid=1, cnt=1, where w=win(req, ptr).
  - Latency: req sampled at edge t gives grant visible after edge t, i.e. one registered cycle.
  - If req==0, stay in IDLE with all outputs unchanged.
- GRANT state, with owner o=sel:
  - rel = done | ~req[o] | (cnt==MAX_HOLD).
  - If rel=0: cnt=cnt+1, all outputs hold.
  - If rel=1: ptr=(o+1) mod 8 (3-bit natural wrap). Let c = req & ~onehot(o).
    - c!=0: grant=onehot(win(c, o+1)), sel updates, valid stays 1, cnt=1. No bubble cycle.
    - c==0 and req[o]=1 and done=0 (quantum expiry only): the owner is re-granted, grant unchanged, cnt=1.
    - Otherwise: state=IDLE, grant=0, valid=0. sel keeps its last value; the mux output is don't-care when valid=0.
- Simultaneous events:
  - done and quantum expiry in the same cycle are treated as done.
  - A request deassert in the same cycle as done is treated as done.
  - New requests arriving in the release cycle are eligible in that same arbitration.
- Fairness: each requester waits at most 7×MAX_HOLD cycles once its request is held continuously.
- Invariants:
  - grant is always zero or one-hot.
  - grant==onehot(sel) whenever valid=1.
  - valid==(grant!=0).
  - cnt never exceeds MAX_HOLD.
- MAX_HOLD=1 is legal: every grant lasts exactly one cycle, and requesters rotate every cycle.

Test Plan:
- Reset check: rst=1 for 2 cycles with req=8'hFF, done=1 -> grant=00, sel=0, valid=0 throughout. Release rst with req=8'h00 -> outputs stay idle.
- Single requester: req=8'h20 held, done=0, MAX_HOLD=4 -> grant=20 and sel=5 one cycle after req. The grant stays after cnt reaches 4 (re-grant, no gap). done=1 for one cycle -> grant=00, valid=0 on the next edge if req is dropped together with done.
- Round robin: req=8'hFF held, done=0, MAX_HOLD=2 -> sel sequence 0,0,1,1,2,2,...,7,7,0,0. No idle cycle. grant is always one-hot and matches sel.
- Wrap and skip: ptr=6 after granting 5, req=8'h09 -> next grant is bit 0 (sel=0), then bit 3. Requesters 6 and 7 are skipped without a bubble.
- Early release: owner 2 deasserts req[2] after 1 cycle while req[4] is set -> grant moves to 10 (sel=4) on the very next edge with cnt=1. Then done=1 with req=8'h00 -> IDLE.
- Reset mid-grant: with grant=08 and cnt=3, assert rst for 1 cycle -> grant=00, ptr=0 at that edge. After release with req=8'h88 -> first grant is bit 3 (scan starts from 0).
